// File: rtl/dfr_pkg.sv
// Shared types and width/saturation helpers for the reservoir readout layer.
package dfr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUTPUT
   } state_t;

   function automatic int prod_width(input int dw, input int ww);
      return dw + ww;
   endfunction

   // Headroom of clog2(nodes) bits keeps a full dot product exact.
   function automatic int acc_width(input int dw, input int ww, input int vn);
      return dw + ww + $clog2(vn);
   endfunction

   function automatic logic signed [63:0] sat_max(input int dw);
      return (64'sd1 <<< (dw - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int dw);
      return -(64'sd1 <<< (dw - 1));
   endfunction

endpackage

// File: rtl/dfr_readout_if.sv
// Node-state beat stream in, saturated result out; both valid/ready.
interface dfr_readout_if #(
   parameter int DATA_WIDTH = 32
);
   logic                         node_valid;
   logic                         node_ready;
   logic signed [DATA_WIDTH-1:0] node_data;
   logic                         node_last;
   logic                         y_valid;
   logic                         y_ready;
   logic signed [DATA_WIDTH-1:0] y_data;
   logic                         y_sat;

   modport master (
      output node_valid, node_data, node_last, y_ready,
      input  node_ready, y_valid, y_data, y_sat
   );

   modport slave (
      input  node_valid, node_data, node_last, y_ready,
      output node_ready, y_valid, y_data, y_sat
   );
endinterface

// File: rtl/dfr_mac.sv
// Signed MAC with first-beat load select, plus the shift-and-saturate output stage.
module dfr_mac
   import dfr_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int WEIGHT_WIDTH  = 16,
   parameter int VIRTUAL_NODES = 10,
   parameter int FRAC_BITS     = 8,
   parameter int ACC_W         = acc_width(DATA_WIDTH, WEIGHT_WIDTH, VIRTUAL_NODES)
) (
   input  logic signed [ACC_W-1:0]        acc,
   input  logic signed [DATA_WIDTH-1:0]   node_data,
   input  logic signed [WEIGHT_WIDTH-1:0] weight,
   input  logic signed [WEIGHT_WIDTH-1:0] bias,
   input  logic                           load,
   output logic signed [ACC_W-1:0]        acc_next,
   output logic signed [DATA_WIDTH-1:0]   y_data,
   output logic                           y_sat
);
   localparam int PROD_W = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_WIDTH));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_WIDTH));

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  shifted;
   logic                     sat_hi;
   logic                     sat_lo;

   assign prod     = PROD_W'(node_data) * PROD_W'(weight);
   assign bias_ext = ACC_W'(bias) <<< FRAC_BITS;
   assign base     = load ? bias_ext : acc;
   assign acc_next = base + ACC_W'(prod);

   assign shifted = acc >>> FRAC_BITS;
   assign sat_hi  = shifted > SAT_HI;
   assign sat_lo  = shifted < SAT_LO;
   assign y_sat   = sat_hi | sat_lo;
   assign y_data  = sat_hi ? DATA_WIDTH'(SAT_HI) :
                    sat_lo ? DATA_WIDTH'(SAT_LO) : shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/dfr_readout.sv
// Reservoir readout: per-sample weighted dot product of node states, saturated output.
// Optional bias term at address VIRTUAL_NODES when DFR_READOUT_BIAS_EN is defined.
module dfr_readout
   import dfr_pkg::*;
#(
   parameter int VIRTUAL_NODES = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int WEIGHT_WIDTH  = 16,
   parameter int FRAC_BITS     = 8,
   parameter int ADDR_WIDTH    = $clog2(VIRTUAL_NODES + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   dfr_readout_if.slave                   bus,
   input  logic                           w_wr_en,
   input  logic [ADDR_WIDTH-1:0]          w_addr,
   input  logic signed [WEIGHT_WIDTH-1:0] w_data,
   output logic                           err_len
);
   localparam int ACC_W = acc_width(DATA_WIDTH, WEIGHT_WIDTH, VIRTUAL_NODES);

   state_t                         state_reg, state_next;
   logic [ADDR_WIDTH-1:0]          idx_reg;
   logic signed [ACC_W-1:0]        acc_reg, acc_next;
   logic signed [WEIGHT_WIDTH-1:0] weight_arr [VIRTUAL_NODES];
   logic signed [WEIGHT_WIDTH-1:0] rd_weight, bias_val;
   logic                           node_ready, y_valid;
   logic                           beat, last_idx, end_beat, y_done;

   genvar gi;
   generate
      for (gi = 0; gi < VIRTUAL_NODES; gi++) begin : g_weight
         logic signed [WEIGHT_WIDTH-1:0] w_reg;
         always_ff @(posedge clk) begin
            if (rst)
               w_reg <= '0;
            else if (w_wr_en && w_addr == ADDR_WIDTH'(gi))
               w_reg <= w_data;
         end
         assign weight_arr[gi] = w_reg;
      end
   endgenerate

`ifdef DFR_READOUT_BIAS_EN
   logic signed [WEIGHT_WIDTH-1:0] bias_reg;
   always_ff @(posedge clk) begin
      if (rst)
         bias_reg <= '0;
      else if (w_wr_en && w_addr == ADDR_WIDTH'(VIRTUAL_NODES))
         bias_reg <= w_data;
   end
   assign bias_val = bias_reg;
`else
   assign bias_val = '0;
`endif

   // Read happens before this cycle's write lands, so a same-cycle rewrite uses the old weight.
   assign rd_weight = weight_arr[idx_reg];

   dfr_mac #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .VIRTUAL_NODES(VIRTUAL_NODES),
      .FRAC_BITS    (FRAC_BITS),
      .ACC_W        (ACC_W)
   ) u_mac (
      .acc      (acc_reg),
      .node_data(bus.node_data),
      .weight   (rd_weight),
      .bias     (bias_val),
      .load     (state_reg == IDLE),
      .acc_next (acc_next),
      .y_data   (bus.y_data),
      .y_sat    (bus.y_sat)
   );

   always_comb begin
      state_next = state_reg;
      node_ready = (state_reg != OUTPUT);
      y_valid    = (state_reg == OUTPUT);
      beat       = bus.node_valid & node_ready;
      last_idx   = (idx_reg == ADDR_WIDTH'(VIRTUAL_NODES - 1));
      end_beat   = beat & (bus.node_last | last_idx);
      y_done     = y_valid & bus.y_ready;
      err_len    = end_beat & (bus.node_last ^ last_idx) & ~rst;
      case (state_reg)
         IDLE, ACCUM: if (beat) state_next = end_beat ? OUTPUT : ACCUM;
         OUTPUT:      if (bus.y_ready) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   assign bus.node_ready = node_ready;
   assign bus.y_valid    = y_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (beat) begin
            acc_reg <= acc_next;
            idx_reg <= idx_reg + 1'b1;
         end else if (y_done) begin
            acc_reg <= '0;
            idx_reg <= '0;
         end
      end
   end
endmodule

// File: tb/tb_dfr_readout.sv
// Directed and randomized checks of dfr_readout against a dot-product reference model.
module tb_dfr_readout;
   localparam int VN = 10;
   localparam int DW = 32;
   localparam int WW = 16;
   localparam int FB = 8;
   localparam int AW = $clog2(VN + 1);
`ifdef DFR_READOUT_BIAS_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif
   localparam longint YMAX = (64'sd1 <<< (DW - 1)) - 1;
   localparam longint YMIN = -(64'sd1 <<< (DW - 1));

   logic clk = 1'b0;
   logic rst;
   logic w_wr_en;
   logic [AW-1:0] w_addr;
   logic signed [WW-1:0] w_data;
   logic err_len;

   always #5 clk = ~clk;

   dfr_readout_if #(.DATA_WIDTH(DW)) bus ();

   dfr_readout #(
      .VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .FRAC_BITS(FB), .ADDR_WIDTH(AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.slave),
      .w_wr_en(w_wr_en),
      .w_addr (w_addr),
      .w_data (w_data),
      .err_len(err_len)
   );

   int checks = 0;
   int failures = 0;
   longint mw[VN];
   longint mb;
   longint nv[VN];

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < VN; i++) mw[i] = 0;
      mb = 0;
   endtask

   task automatic model_write(input int addr, input longint val);
      if (addr < VN) mw[addr] = val;
      else if (addr == VN && BIAS) mb = val;
   endtask

   task automatic write_w(input int addr, input longint val);
      @(negedge clk);
      w_wr_en = 1'b1;
      w_addr  = AW'(addr);
      w_data  = val[WW-1:0];
      @(posedge clk);
      model_write(addr, val);
      #1 w_wr_en = 1'b0;
   endtask

   task automatic set_all(input longint val);
      for (int a = 0; a < VN; a++) write_w(a, val);
   endtask

   // One sample of n beats; optional weight write during beat wr_beat; y_ready held low for hold cycles.
   task automatic run_sample(input int n, input bit with_last, input int hold,
                             input int wr_beat, input int wr_addr, input longint wr_val);
      longint acc, sh, exp_y;
      bit     exp_sat, lastb;
      acc = mb <<< FB;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         lastb = with_last && (i == n - 1);
         bus.node_valid = 1'b1;
         bus.node_data  = nv[i][DW-1:0];
         bus.node_last  = lastb;
         if (i == wr_beat) begin
            w_wr_en = 1'b1;
            w_addr  = AW'(wr_addr);
            w_data  = wr_val[WW-1:0];
         end
         #1;
         chk("node_ready_beat", 64'(bus.node_ready), 1);
         chk("y_valid_busy", 64'(bus.y_valid), 0);
         chk("err_len", 64'(err_len), 64'((i == n - 1) && (lastb != (i == VN - 1))));
         acc += nv[i] * mw[i];
         @(posedge clk);
         if (i == wr_beat) model_write(wr_addr, wr_val);
         #1 w_wr_en = 1'b0;
      end
      @(negedge clk);
      bus.node_valid = 1'b0;
      bus.node_last  = 1'b0;
      sh = acc >>> FB;
      exp_sat = (sh > YMAX) || (sh < YMIN);
      exp_y = (sh > YMAX) ? YMAX : (sh < YMIN) ? YMIN : sh;
      #1;
      chk("y_valid", 64'(bus.y_valid), 1);
      chk("y_data", 64'(bus.y_data), exp_y);
      chk("y_sat", 64'(bus.y_sat), 64'(exp_sat));
      chk("node_ready_out", 64'(bus.node_ready), 0);
      chk("err_len_idle", 64'(err_len), 0);
      bus.y_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         chk("y_valid_hold", 64'(bus.y_valid), 1);
         chk("y_data_hold", 64'(bus.y_data), exp_y);
         chk("y_sat_hold", 64'(bus.y_sat), 64'(exp_sat));
         chk("node_ready_hold", 64'(bus.node_ready), 0);
         if (h == hold - 1) bus.y_ready = 1'b1;
      end
      @(negedge clk);
      #1;
      chk("y_valid_done", 64'(bus.y_valid), 0);
      $display("sample n=%0d last=%0b hold=%0d y=%0d sat=%0b", n, with_last, hold, exp_y, exp_sat);
   endtask

   initial begin
      logic signed [31:0] rd;
      logic signed [15:0] rw;
      int n, wb;
      bit wl;

      rst = 1'b1;
      w_wr_en = 1'b0;
      w_addr = '0;
      w_data = '0;
      bus.node_valid = 1'b0;
      bus.node_data = '0;
      bus.node_last = 1'b0;
      bus.y_ready = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_node_ready", 64'(bus.node_ready), 1);
      chk("rst_y_valid", 64'(bus.y_valid), 0);
      chk("rst_y_data", 64'(bus.y_data), 0);
      chk("rst_y_sat", 64'(bus.y_sat), 0);
      chk("rst_err_len", 64'(err_len), 0);
      rst = 1'b0;

      // Unity weights, full sample
      set_all(256);
      for (int i = 0; i < VN; i++) nv[i] = i + 1;
      run_sample(VN, 1'b1, 0, -1, 0, 0);

      // Negative weight, backpressure, then an immediate follow-on sample
      set_all(0);
      write_w(0, -256);
      nv[0] = 100;
      run_sample(1, 1'b1, 5, -1, 0, 0);
      nv[0] = 7;
      run_sample(1, 1'b1, 0, -1, 0, 0);

      // Saturation both directions
      set_all(32767);
      for (int i = 0; i < VN; i++) nv[i] = 64'sh7FFF_FFFF;
      run_sample(VN, 1'b1, 0, -1, 0, 0);
      for (int i = 0; i < VN; i++) nv[i] = -64'sh8000_0000;
      run_sample(VN, 1'b1, 0, -1, 0, 0);

      // Length errors: early node_last, then missing node_last
      set_all(256);
      nv[0] = 5; nv[1] = 6; nv[2] = 7;
      run_sample(3, 1'b1, 0, -1, 0, 0);
      for (int i = 0; i < VN; i++) nv[i] = i + 1;
      run_sample(VN, 1'b0, 0, -1, 0, 0);

      // Same-cycle weight rewrite uses the old weight
      for (int i = 0; i < VN; i++) nv[i] = 0;
      nv[2] = 10;
      run_sample(VN, 1'b1, 0, 2, 2, 512);
      run_sample(VN, 1'b1, 0, -1, 0, 0);

      // Reset mid-sample
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.node_valid = 1'b1;
         bus.node_data = 32'sd9;
         bus.node_last = 1'b0;
      end
      @(negedge clk);
      bus.node_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_y_valid", 64'(bus.y_valid), 0);
      chk("midrst_node_ready", 64'(bus.node_ready), 1);
      chk("midrst_y_data", 64'(bus.y_data), 0);
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < VN; i++) nv[i] = 1000;
      run_sample(VN, 1'b1, 0, -1, 0, 0);
      set_all(256);
      write_w(VN, 3);
      write_w((1 << AW) - 1, 999);
      for (int i = 0; i < VN; i++) nv[i] = 1;
      run_sample(VN, 1'b1, 0, -1, 0, 0);

      // Randomized samples with weight updates and backpressure
      for (int t = 0; t < 30; t++) begin
         repeat ($urandom_range(0, 3)) begin
            rw = 16'($urandom);
            write_w($urandom_range(0, VN), longint'(rw));
         end
         n = $urandom_range(1, VN);
         wl = (n < VN) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < VN; i++) begin
            rd = $urandom;
            nv[i] = ($urandom_range(0, 3) == 0) ? longint'(rd) : longint'(rd >>> 12);
         end
         wb = $urandom_range(0, n);
         rw = 16'($urandom);
         run_sample(n, wl, $urandom_range(0, 3), wb, $urandom_range(0, VN), longint'(rw));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
